// File: rtl/debug_defs.sv
// Shared definitions for the debug-unit blocks: memory-dump FSM encodings,
// bytes-per-word constant and small sizing helpers.
package debug_defs;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_ADDR = 3'd1,
        ST_LATCH    = 3'd2,
        ST_SEND     = 3'd3,
        ST_DONE     = 3'd4
    } dump_state_e;

    localparam int unsigned DEBUG_NBITS    = 32;
    localparam int unsigned BYTES_PER_WORD = DEBUG_NBITS / 8;

    function automatic int unsigned bytes_per_word(input int unsigned nbits);
        return nbits / 8;
    endfunction

    // Counter width for n states, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debug_mem_dump_word_serializer.sv
// Splits one loaded word into bytes, MSB byte first, under a valid/ready
// handshake; flags the last byte so the controller knows when the word ends.
module word_serializer
    import debug_defs::*;
#(
    parameter int unsigned NBITS = 32,
    parameter int unsigned BPW   = NBITS / 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [NBITS-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [7:0]       byte_o,
    output logic             last_o,
    output logic             xfer_o
);

    localparam int unsigned CW = cnt_width(BPW);
    localparam logic [CW-1:0] CNT_LAST = CW'(BPW - 1);

    logic [NBITS-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;

    assign xfer_o  = valid_q & ready_i;
    assign last_o  = (cnt_q == CNT_LAST);
    assign valid_o = valid_q;
    assign byte_o  = shift_q[NBITS-1 -: 8];

    // Next-state: a load restarts the word; a transfer shifts in zeros.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = data_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (xfer_o) begin
            shift_d = {shift_q[NBITS-9:0], 8'h00};
            cnt_d   = cnt_q + CW'(1);
            valid_d = ~last_o;
        end else begin
            shift_d = shift_q;
        end
    end

    // Serializer state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/debug_mem_dump.sv
// Walks the data memory through its debug read port and streams every word
// to the UART transmitter, MSB byte first, then pulses o_Done.
module debug_mem_dump
    import debug_defs::*;
#(
    parameter int unsigned NBITS  = 32,
    parameter int unsigned CELDAS = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_Start,
    output logic [NBITS-1:0] o_DebugDireccion,
    input  logic [NBITS-1:0] i_DebugDato,
    output logic [7:0]       o_TxDato,
    output logic             o_TxValid,
    input  logic             i_TxReady,
    output logic             o_Busy,
    output logic             o_Done
);

    localparam int unsigned BPW = bytes_per_word(NBITS);
    localparam int unsigned AW  = cnt_width(CELDAS);
    localparam logic [AW-1:0] ADDR_LAST = AW'(CELDAS - 1);

    dump_state_e      state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [NBITS-1:0] dir_q, dir_d;
    logic             busy_q, done_q;
    logic             load_s, xfer_s, last_s;

    word_serializer #(
        .NBITS (NBITS),
        .BPW   (BPW)
    ) u_ser (
        .clk_i   (i_clk),
        .reset_i (i_reset),
        .load_i  (load_s),
        .data_i  (i_DebugDato),
        .ready_i (i_TxReady),
        .valid_o (o_TxValid),
        .byte_o  (o_TxDato),
        .last_o  (last_s),
        .xfer_o  (xfer_s)
    );

    // FSM next-state, address counter and debug address selection.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dir_d   = dir_q;
        load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    addr_d  = '0;
                    state_d = ST_SET_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SET_ADDR: state_d = ST_LATCH;
            ST_LATCH: begin
                load_s  = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (xfer_s && last_s) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = ST_SET_ADDR;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // The address register is only rewritten on entry to SET_ADDR, so it
        // stays put through LATCH and holds its last value afterwards.
        if (state_d == ST_SET_ADDR) begin
            dir_d = NBITS'(addr_d);
        end else begin
            dir_d = dir_q;
        end
    end

    // State, address and status registers; o_Done is registered off the
    // DONE state so it follows the last transfer by two cycles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            dir_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dir_q   <= dir_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_q == ST_DONE);
        end
    end

    assign o_DebugDireccion = dir_q;
    assign o_Busy           = busy_q;
    assign o_Done           = done_q;

endmodule

// File: tb/tb_debug_mem_dump.sv
// Scoreboard bench for debug_mem_dump: drivers push expected bytes, a
// negedge monitor pops and compares every accepted byte and every o_Done.
module tb_debug_mem_dump;

    localparam int NBITS  = 32;
    localparam int CELDAS = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             ready;
    logic [NBITS-1:0] dir;
    logic [NBITS-1:0] dato;
    logic [7:0]       txd;
    logic             txv;
    logic             busy;
    logic             done;

    logic [NBITS-1:0] mem [CELDAS];
    logic [7:0]       expq [$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int nbytes = 0;
    int done_cnt = 0;
    int start_cyc = 0;
    int last_xfer_cyc = 0;
    bit first_pending = 1'b0;
    bit stall_prev = 1'b0;
    logic [7:0] stall_byte = 8'h00;

    debug_mem_dump #(.NBITS(NBITS), .CELDAS(CELDAS)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_Start          (start),
        .o_DebugDireccion (dir),
        .i_DebugDato      (dato),
        .o_TxDato         (txd),
        .o_TxValid        (txv),
        .i_TxReady        (ready),
        .o_Busy           (busy),
        .o_Done           (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign dato = mem[dir[3:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: byte scoreboard, stall stability, start and done latency.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_valid", 32'(txv), 32'd1);
                check("stall_hold_byte", 32'(txd), 32'(stall_byte));
            end
            if (txv && first_pending) begin
                check("first_valid_latency", 32'(cyc - start_cyc), 32'd3);
                check("busy_in_dump", 32'(busy), 32'd1);
                first_pending = 1'b0;
            end
            if (txv && ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_byte", 32'(expq.size()), 32'd1);
                end else begin
                    check("byte", 32'(txd), 32'(expq.pop_front()));
                end
                nbytes++;
                last_xfer_cyc = cyc;
            end
            stall_prev = txv && !ready;
            stall_byte = txd;
            if (done) begin
                check("done_latency", 32'(cyc - last_xfer_cyc), 32'd2);
                check("done_queue_empty", 32'(expq.size()), 32'd0);
                done_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_dump();
        logic [NBITS-1:0] w;
        for (int i = 0; i < CELDAS; i++) begin
            w = mem[i];
            for (int b = 0; b < 4; b++) expq.push_back(w[31 - 8*b -: 8]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        start_cyc = cyc;
        first_pending = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (done_cnt == prev && n < 400) begin
            tick(1);
            n++;
        end
        if (done_cnt == prev) check("done_timeout", 32'(done_cnt), 32'(prev + 1));
    endtask

    task automatic wait_bytes(input int target);
        int n = 0;
        while (nbytes < target && n < 400) begin
            tick(1);
            n++;
        end
        if (nbytes < target) check("byte_wait_timeout", 32'(nbytes), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n0;
        int k;
        rst = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < CELDAS; i++) mem[i] = 32'(i);
        tick(3);
        check("rst_dir", dir, 32'd0);
        check("rst_txd", 32'(txd), 32'd0);
        check("rst_txv", 32'(txv), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick(2);

        // Full dump of memory[i] = i with the transmitter always ready.
        d0 = done_cnt; n0 = nbytes;
        push_dump();
        pulse_start();
        wait_done(d0);
        tick(3);
        check("a_byte_count", 32'(nbytes - n0), 32'd64);
        check("a_done_count", 32'(done_cnt - d0), 32'd1);
        check("a_dir_hold", dir, 32'd15);
        check("a_busy_idle", 32'(busy), 32'd0);
        check("a_txv_idle", 32'(txv), 32'd0);

        // Back-pressure for 5 cycles while 0xB2 of word 2 is on offer.
        mem[2] = 32'hA1B2C3D4;
        d0 = done_cnt; n0 = nbytes;
        push_dump();
        pulse_start();
        k = 0;
        while (!(txv && txd == 8'hB2) && k < 100) begin
            tick(1);
            k++;
        end
        check("b_found_b2", 32'(txd), 32'h0000_00B2);
        ready = 1'b0;
        tick(5);
        check("b_stall_byte", 32'(txd), 32'h0000_00B2);
        check("b_stall_valid", 32'(txv), 32'd1);
        ready = 1'b1;
        wait_done(d0);
        tick(3);
        check("b_byte_count", 32'(nbytes - n0), 32'd64);
        check("b_done_count", 32'(done_cnt - d0), 32'd1);

        // A second i_Start mid-dump must be ignored.
        d0 = done_cnt; n0 = nbytes;
        push_dump();
        pulse_start();
        wait_bytes(n0 + 10);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(d0);
        tick(10);
        check("c_byte_count", 32'(nbytes - n0), 32'd64);
        check("c_done_count", 32'(done_cnt - d0), 32'd1);
        check("c_busy_idle", 32'(busy), 32'd0);

        // Reset after 20 bytes aborts the dump with no o_Done.
        d0 = done_cnt; n0 = nbytes;
        push_dump();
        pulse_start();
        wait_bytes(n0 + 20);
        rst = 1'b1;
        ready = 1'b0;
        tick(1);
        check("d_rst_dir", dir, 32'd0);
        check("d_rst_txd", 32'(txd), 32'd0);
        check("d_rst_txv", 32'(txv), 32'd0);
        check("d_rst_busy", 32'(busy), 32'd0);
        check("d_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        ready = 1'b1;
        expq.delete();
        tick(3);
        check("d_abort_bytes", 32'(nbytes - n0), 32'd20);
        check("d_abort_no_done", 32'(done_cnt - d0), 32'd0);
        n0 = nbytes;
        push_dump();
        pulse_start();
        wait_done(d0);
        tick(3);
        check("d_restart_bytes", 32'(nbytes - n0), 32'd64);
        check("d_restart_done", 32'(done_cnt - d0), 32'd1);

        // i_Start together with i_reset leaves the block idle.
        d0 = done_cnt;
        start = 1'b1;
        rst = 1'b1;
        tick(1);
        start = 1'b0;
        rst = 1'b0;
        check("e_busy", 32'(busy), 32'd0);
        check("e_txv", 32'(txv), 32'd0);
        tick(4);
        check("e_busy_later", 32'(busy), 32'd0);
        check("e_txv_later", 32'(txv), 32'd0);
        check("e_no_done", 32'(done_cnt - d0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
